// File: rtl/rtl_settings_pkg.sv
// Shared widths, types and helpers for the memory test read path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rtl_settings_pkg;

  localparam int AMM_DATA_W = 512;
  localparam int DATA_B_W   = AMM_DATA_W / 8;
  localparam int ADDR_B_W   = $clog2(DATA_B_W);
  localparam int CMP_ADDR_W = 26;
  localparam int ADDR_W     = CMP_ADDR_W + ADDR_B_W;
  localparam int BURST_W    = 8;

  // Error address reporting granularity.
  typedef enum logic {
    BYTE = 1'b0,
    WORD = 1'b1
  } addr_type_t;

  localparam addr_type_t ADDR_TYPE = BYTE;

  typedef enum logic {
    FIX_DATA = 1'b0,
    RND_DATA = 1'b1
  } data_type_t;

  // Read-side compare descriptor produced by the read-request generator.
  typedef struct packed {
    logic                  trans_type;   // 1 = burst of words_count+1 words
    logic [BURST_W-1:0]    words_count;
    logic [CMP_ADDR_W-1:0] start_addr;   // word address
    logic [ADDR_B_W-1:0]   start_off;    // first enabled byte of first word
    logic [ADDR_B_W-1:0]   end_off;      // last enabled byte of last word
    data_type_t            ptrn_type;
    logic [7:0]            data_ptrn;
  } cmp_struct_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } cmp_state_t;

  typedef struct packed {
    logic                  valid;
    logic [CMP_ADDR_W-1:0] word_addr;
    logic [DATA_B_W-1:0]   mask;
    logic [7:0]            exp;
    logic [AMM_DATA_W-1:0] data;
  } check_stage_t;

  // Galois LFSR step, polynomial x^8+x^6+x^5+x^4+1 (feedback mask 0x71).
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    lfsr8_next = {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
  endfunction

endpackage

// File: rtl/byteenable_ptrn.sv
// Byte enable mask for one data word from start/end byte offsets.
// Latency: combinational.
// Backpressure: none.
module byteenable_ptrn
  import rtl_settings_pkg::*;
(
  input  logic [ADDR_B_W-1:0] start_off_i,
  input  logic [ADDR_B_W-1:0] end_off_i,
  input  logic                start_enable_i,
  input  logic                end_enable_i,
  output logic [DATA_B_W-1:0] mask_o
);

  // A byte is enabled when it lies inside whichever bounds are active.
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < DATA_B_W; i++) begin
      mask_o[i] = (!start_enable_i || (ADDR_B_W'(i) >= start_off_i)) &&
                  (!end_enable_i   || (ADDR_B_W'(i) <= end_off_i));
    end
  end

endmodule

// File: rtl/check_vector.sv
// Per-byte mismatch vector of a data word against one expected byte.
// Latency: combinational.
// Backpressure: none.
module check_vector
  import rtl_settings_pkg::*;
(
  input  logic [AMM_DATA_W-1:0] data_i,
  input  logic [DATA_B_W-1:0]   mask_i,
  input  logic [7:0]            exp_i,
  output logic [DATA_B_W-1:0]   vec_o
);

  // Only enabled bytes can flag a mismatch.
  always_comb begin
    vec_o = '0;
    for (int i = 0; i < DATA_B_W; i++) begin
      vec_o[i] = mask_i[i] && (data_i[i*8 +: 8] != exp_i);
    end
  end

endmodule

// File: rtl/err_byte_find.sv
// Finds the lowest flagged byte in a mismatch vector.
// Latency: combinational.
// Backpressure: none.
module err_byte_find
  import rtl_settings_pkg::*;
(
  input  logic [DATA_B_W-1:0] vec_i,
  output logic                found_o,
  output logic [ADDR_B_W-1:0] idx_o
);

  // Scan from the top down so the lowest set bit is the one left standing.
  always_comb begin
    found_o = |vec_i;
    idx_o   = '0;
    for (int i = DATA_B_W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = ADDR_B_W'(i);
      end
    end
  end

endmodule

// File: rtl/read_data_checker_pipe.sv
// Three-stage compare datapath: S0 capture, S1 byte compare, S2 error latch/counters.
// Latency: results visible 3 cycles after the beat enters S0.
// Backpressure: none; accepts one beat per cycle, clear_i flushes all stages.
module read_data_checker_pipe
  import rtl_settings_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  check_stage_t          s0_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [ADDR_W-1:0]     err_addr_o,
  output logic [7:0]            err_data_o,
  output logic [7:0]            err_exp_o,
  output logic [CNT_W-1:0]      words_checked_o,
  output logic [CNT_W-1:0]      err_cnt_o
);

  check_stage_t          s0_q, s0_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [CMP_ADDR_W-1:0] s1_word_addr_q, s1_word_addr_d;
  logic [7:0]            s1_exp_q, s1_exp_d;
  logic [AMM_DATA_W-1:0] s1_data_q, s1_data_d;
  logic [DATA_B_W-1:0]   s1_vec_q, s1_vec_d;

  logic                  err_q, err_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
  logic [7:0]            err_data_q, err_data_d;
  logic [7:0]            err_exp_q, err_exp_d;
  logic [CNT_W-1:0]      words_q, words_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;

  logic [DATA_B_W-1:0]   vec;
  logic                  found;
  logic [ADDR_B_W-1:0]   err_byte;
  logic [ADDR_W-1:0]     cur_addr;

  check_vector u_check_vector (
    .data_i (s0_q.data),
    .mask_i (s0_q.mask),
    .exp_i  (s0_q.exp),
    .vec_o  (vec)
  );

  err_byte_find u_err_byte_find (
    .vec_i   (s1_vec_q),
    .found_o (found),
    .idx_o   (err_byte)
  );

  // S0 capture and S1 compare; a clear drops whatever is in flight.
  always_comb begin
    s0_d = s0_i;
    if (clear_i) begin
      s0_d.valid = 1'b0;
    end
    s1_valid_d     = s0_q.valid && !clear_i;
    s1_word_addr_d = s0_q.word_addr;
    s1_exp_d       = s0_q.exp;
    s1_data_d      = s0_q.data;
    s1_vec_d       = vec;
  end

  // Reported address of the offending byte (or word).
  always_comb begin
    if (ADDR_TYPE == BYTE) begin
      cur_addr = {s1_word_addr_q, err_byte};
    end else begin
      cur_addr = ADDR_W'(s1_word_addr_q);
    end
  end

  // S2: count every word, count erroneous words, latch only the first error.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    err_exp_d  = err_exp_q;
    words_d    = words_q;
    err_cnt_d  = err_cnt_q;
    if (clear_i) begin
      err_d      = 1'b0;
      err_addr_d = '0;
      err_data_d = '0;
      err_exp_d  = '0;
      words_d    = '0;
      err_cnt_d  = '0;
    end else if (s1_valid_q) begin
      words_d = words_q + 1'b1;
      if (found) begin
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        if (!err_q) begin
          err_d      = 1'b1;
          err_addr_d = cur_addr;
          err_data_d = s1_data_q[{err_byte, 3'b000} +: 8];
          err_exp_d  = s1_exp_q;
        end
      end
    end
  end

  // Pipeline and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0_q           <= '0;
      s1_valid_q     <= 1'b0;
      s1_word_addr_q <= '0;
      s1_exp_q       <= '0;
      s1_data_q      <= '0;
      s1_vec_q       <= '0;
      err_q          <= 1'b0;
      err_addr_q     <= '0;
      err_data_q     <= '0;
      err_exp_q      <= '0;
      words_q        <= '0;
      err_cnt_q      <= '0;
    end else begin
      s0_q           <= s0_d;
      s1_valid_q     <= s1_valid_d;
      s1_word_addr_q <= s1_word_addr_d;
      s1_exp_q       <= s1_exp_d;
      s1_data_q      <= s1_data_d;
      s1_vec_q       <= s1_vec_d;
      err_q          <= err_d;
      err_addr_q     <= err_addr_d;
      err_data_q     <= err_data_d;
      err_exp_q      <= err_exp_d;
      words_q        <= words_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign busy_o          = s0_q.valid | s1_valid_q;
  assign err_o           = err_q;
  assign err_addr_o      = err_addr_q;
  assign err_data_o      = err_data_q;
  assign err_exp_o       = err_exp_q;
  assign words_checked_o = words_q;
  assign err_cnt_o       = err_cnt_q;

endmodule

// File: rtl/read_data_checker.sv
// Checks Avalon-MM read data against compare descriptors; latches the first mismatch.
// Latency: error/counters update 3 cycles after each readdatavalid_i beat.
// Backpressure: cmp_ready_o high in IDLE and on the last beat of the current descriptor.
module read_data_checker
  import rtl_settings_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  test_start_i,
  input  cmp_struct_t           cmp_struct_i,
  input  logic                  cmp_valid_i,
  output logic                  cmp_ready_o,
  input  logic                  readdatavalid_i,
  input  logic [AMM_DATA_W-1:0] readdata_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [ADDR_W-1:0]     err_addr_o,
  output logic [7:0]            err_data_o,
  output logic [7:0]            err_exp_o,
  output logic [CNT_W-1:0]      words_checked_o,
  output logic [CNT_W-1:0]      err_cnt_o,
  output logic                  orphan_o
);

  cmp_state_t         state_q, state_d;
  cmp_struct_t        desc_q, desc_d;
  logic [BURST_W-1:0] word_idx_q, word_idx_d;
  logic [7:0]         exp_q, exp_d;
  logic               orphan_q, orphan_d;
  logic               rdy_en_q;

  logic                beat;
  logic                is_last;
  logic                accept;
  logic                pipe_busy;
  logic [DATA_B_W-1:0] mask;
  check_stage_t        s0_in;

  assign beat    = (state_q == CHECK) && readdatavalid_i;
  assign is_last = !desc_q.trans_type || (word_idx_q == desc_q.words_count);

  // Ready in IDLE, and on the last beat so the next descriptor follows with no bubble.
  always_comb begin
    cmp_ready_o = rdy_en_q && ((state_q == IDLE) || (beat && is_last));
  end

  assign accept = cmp_valid_i && cmp_ready_o;

  // FSM, word index and expected-pattern sequencing; a clear overrides all but an accept.
  always_comb begin
    state_d    = state_q;
    desc_d     = desc_q;
    word_idx_d = word_idx_q;
    exp_d      = exp_q;
    orphan_d   = orphan_q;
    if ((state_q == IDLE) && readdatavalid_i) begin
      orphan_d = 1'b1;
    end
    if (beat) begin
      word_idx_d = word_idx_q + 1'b1;
      if (desc_q.ptrn_type == RND_DATA) begin
        exp_d = lfsr8_next(exp_q);
      end
      if (is_last) begin
        state_d = IDLE;
      end
    end
    if (accept) begin
      desc_d     = cmp_struct_i;
      word_idx_d = '0;
      exp_d      = cmp_struct_i.data_ptrn;
      state_d    = CHECK;
    end
    if (test_start_i) begin
      orphan_d = 1'b0;
      if (!accept) begin
        state_d = IDLE;
      end
    end
  end

  // Control registers; rdy_en_q holds off ready for the first cycle out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      desc_q     <= '0;
      word_idx_q <= '0;
      exp_q      <= '0;
      orphan_q   <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      desc_q     <= desc_d;
      word_idx_q <= word_idx_d;
      exp_q      <= exp_d;
      orphan_q   <= orphan_d;
      rdy_en_q   <= 1'b1;
    end
  end

  byteenable_ptrn u_byteenable_ptrn (
    .start_off_i    (desc_q.start_off),
    .end_off_i      (desc_q.end_off),
    .start_enable_i (word_idx_q == '0),
    .end_enable_i   (is_last),
    .mask_o         (mask)
  );

  // Beat bundle handed to S0; word address wraps within CMP_ADDR_W.
  always_comb begin
    s0_in.valid     = beat && !test_start_i;
    s0_in.word_addr = desc_q.start_addr + CMP_ADDR_W'(word_idx_q);
    s0_in.mask      = mask;
    s0_in.exp       = exp_q;
    s0_in.data      = readdata_i;
  end

  read_data_checker_pipe #(
    .CNT_W (CNT_W)
  ) u_pipe (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (test_start_i),
    .s0_i            (s0_in),
    .busy_o          (pipe_busy),
    .err_o           (err_o),
    .err_addr_o      (err_addr_o),
    .err_data_o      (err_data_o),
    .err_exp_o       (err_exp_o),
    .words_checked_o (words_checked_o),
    .err_cnt_o       (err_cnt_o)
  );

  assign busy_o   = (state_q == CHECK) | pipe_busy;
  assign orphan_o = orphan_q;

endmodule

// File: tb/tb_read_data_checker.sv
module tb_read_data_checker;
  import rtl_settings_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  test_start_i = 1'b0;
  cmp_struct_t           cmp_struct_i = '0;
  logic                  cmp_valid_i = 1'b0;
  logic                  cmp_ready_o;
  logic                  readdatavalid_i = 1'b0;
  logic [AMM_DATA_W-1:0] readdata_i = '0;
  logic                  busy_o;
  logic                  err_o;
  logic [ADDR_W-1:0]     err_addr_o;
  logic [7:0]            err_data_o;
  logic [7:0]            err_exp_o;
  logic [31:0]           words_checked_o;
  logic [31:0]           err_cnt_o;
  logic                  orphan_o;

  int total  = 0;
  int passed = 0;

  read_data_checker #(.CNT_W(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .test_start_i    (test_start_i),
    .cmp_struct_i    (cmp_struct_i),
    .cmp_valid_i     (cmp_valid_i),
    .cmp_ready_o     (cmp_ready_o),
    .readdatavalid_i (readdatavalid_i),
    .readdata_i      (readdata_i),
    .busy_o          (busy_o),
    .err_o           (err_o),
    .err_addr_o      (err_addr_o),
    .err_data_o      (err_data_o),
    .err_exp_o       (err_exp_o),
    .words_checked_o (words_checked_o),
    .err_cnt_o       (err_cnt_o),
    .orphan_o        (orphan_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic cmp_struct_t mk_desc(input logic tt, input logic [BURST_W-1:0] wc,
                                          input logic [CMP_ADDR_W-1:0] sa,
                                          input logic [ADDR_B_W-1:0] so,
                                          input logic [ADDR_B_W-1:0] eo,
                                          input data_type_t pt, input logic [7:0] p);
    cmp_struct_t d;
    d.trans_type  = tt;
    d.words_count = wc;
    d.start_addr  = sa;
    d.start_off   = so;
    d.end_off     = eo;
    d.ptrn_type   = pt;
    d.data_ptrn   = p;
    return d;
  endfunction

  // All tasks start and end on a negative clock edge.
  task automatic pulse_start();
    test_start_i = 1'b1;
    @(negedge clk_i);
    test_start_i = 1'b0;
  endtask

  task automatic send_desc(input cmp_struct_t d);
    cmp_struct_i = d;
    cmp_valid_i  = 1'b1;
    @(negedge clk_i);
    cmp_valid_i  = 1'b0;
  endtask

  task automatic send_beat(input logic [AMM_DATA_W-1:0] d);
    readdatavalid_i = 1'b1;
    readdata_i      = d;
    @(negedge clk_i);
    readdatavalid_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    total++; if (cmp_ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", cmp_ready_o); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else passed++;
    total++; if (words_checked_o !== 32'd0) $display("FAIL reset_words: got %0d want 0", words_checked_o); else passed++;
    total++; if (orphan_o !== 1'b0) $display("FAIL reset_orphan: got %b want 0", orphan_o); else passed++;
    rst_i = 1'b0;
    #1;
    total++; if (cmp_ready_o !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", cmp_ready_o); else passed++;
    @(negedge clk_i);
    total++; if (cmp_ready_o !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", cmp_ready_o); else passed++;
  endtask

  task automatic test_orphan();
    send_beat({64{8'h12}});
    repeat (3) @(negedge clk_i);
    total++; if (orphan_o !== 1'b1) $display("FAIL orphan_set: got %b want 1", orphan_o); else passed++;
    total++; if (words_checked_o !== 32'd0) $display("FAIL orphan_words: got %0d want 0", words_checked_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL orphan_busy: got %b want 0", busy_o); else passed++;
    pulse_start();
    total++; if (orphan_o !== 1'b0) $display("FAIL orphan_clear: got %b want 0", orphan_o); else passed++;
  endtask

  task automatic test_single_word();
    logic [AMM_DATA_W-1:0] d;
    pulse_start();
    d = {64{8'hA5}};
    d[3*8 +: 8]  = 8'h00;   // below start_off
    d[10*8 +: 8] = 8'hFF;   // above end_off
    send_desc(mk_desc(1'b0, 8'd0, 26'h0, 6'd4, 6'd9, FIX_DATA, 8'hA5));
    send_beat(d);
    repeat (3) @(negedge clk_i);
    total++; if (err_o !== 1'b0) $display("FAIL single_err: got %b want 0", err_o); else passed++;
    total++; if (words_checked_o !== 32'd1) $display("FAIL single_words: got %0d want 1", words_checked_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL single_busy: got %b want 0", busy_o); else passed++;
  endtask

  task automatic test_error_latch();
    logic [AMM_DATA_W-1:0] d;
    pulse_start();
    d = {64{8'hA5}};
    d[7*8 +: 8] = 8'h5A;
    send_desc(mk_desc(1'b0, 8'd0, 26'h10, 6'd4, 6'd9, FIX_DATA, 8'hA5));
    send_beat(d);
    @(negedge clk_i);
    total++; if (err_o !== 1'b0) $display("FAIL err_early: got %b want 0", err_o); else passed++;
    @(negedge clk_i);
    total++; if (err_o !== 1'b1) $display("FAIL err_rise: got %b want 1", err_o); else passed++;
    total++; if (err_addr_o !== 32'h407) $display("FAIL err_addr: got %h want 407", err_addr_o); else passed++;
    total++; if (err_data_o !== 8'h5A) $display("FAIL err_data: got %h want 5a", err_data_o); else passed++;
    total++; if (err_exp_o !== 8'hA5) $display("FAIL err_exp: got %h want a5", err_exp_o); else passed++;
    total++; if (err_cnt_o !== 32'd1) $display("FAIL err_cnt1: got %0d want 1", err_cnt_o); else passed++;
    // Second mismatch at the inclusive end_off byte: counted, not latched.
    d = {64{8'hA5}};
    d[9*8 +: 8] = 8'h00;
    send_desc(mk_desc(1'b0, 8'd0, 26'h55, 6'd4, 6'd9, FIX_DATA, 8'hA5));
    send_beat(d);
    repeat (3) @(negedge clk_i);
    total++; if (err_cnt_o !== 32'd2) $display("FAIL err_cnt2: got %0d want 2", err_cnt_o); else passed++;
    total++; if (err_addr_o !== 32'h407) $display("FAIL err_addr_hold: got %h want 407", err_addr_o); else passed++;
    total++; if (words_checked_o !== 32'd2) $display("FAIL err_words: got %0d want 2", words_checked_o); else passed++;
  endtask

  task automatic test_burst();
    logic [7:0] seq [4];
    logic [AMM_DATA_W-1:0] d;
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h04; seq[3] = 8'h08;
    pulse_start();
    send_desc(mk_desc(1'b1, 8'd3, 26'h20, 6'd2, 6'd60, RND_DATA, 8'h01));
    for (int w = 0; w < 4; w++) send_beat({64{seq[w]}});
    repeat (3) @(negedge clk_i);
    total++; if (words_checked_o !== 32'd4) $display("FAIL burst_words: got %0d want 4", words_checked_o); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL burst_err: got %b want 0", err_o); else passed++;
    pulse_start();
    send_desc(mk_desc(1'b1, 8'd3, 26'h20, 6'd2, 6'd60, RND_DATA, 8'h01));
    for (int w = 0; w < 4; w++) begin
      d = {64{seq[w]}};
      if (w == 0) begin d[7:0] = 8'hEE; d[15:8] = 8'hEE; end   // masked off by start_off
      if (w == 2) d[7:0] = 8'h33;
      send_beat(d);
    end
    repeat (3) @(negedge clk_i);
    total++; if (err_cnt_o !== 32'd1) $display("FAIL burst_err_cnt: got %0d want 1", err_cnt_o); else passed++;
    total++; if (err_addr_o !== 32'h880) $display("FAIL burst_err_addr: got %h want 880", err_addr_o); else passed++;
    total++; if (err_exp_o !== 8'h04) $display("FAIL burst_err_exp: got %h want 04", err_exp_o); else passed++;
    total++; if (err_data_o !== 8'h33) $display("FAIL burst_err_data: got %h want 33", err_data_o); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq_b [4];
    seq_b[0] = 8'h80; seq_b[1] = 8'h71; seq_b[2] = 8'hE2; seq_b[3] = 8'hB5;
    pulse_start();
    send_desc(mk_desc(1'b1, 8'd3, 26'h0, 6'd0, 6'd63, FIX_DATA, 8'h3C));
    for (int w = 0; w < 4; w++) begin
      readdatavalid_i = 1'b1;
      readdata_i      = {64{8'h3C}};
      if (w == 3) begin
        cmp_struct_i = mk_desc(1'b1, 8'd3, 26'h40, 6'd0, 6'd63, RND_DATA, 8'h80);
        cmp_valid_i  = 1'b1;
        #1;
        total++; if (cmp_ready_o !== 1'b1) $display("FAIL b2b_ready_last: got %b want 1", cmp_ready_o); else passed++;
      end else if (w == 1) begin
        #1;
        total++; if (cmp_ready_o !== 1'b0) $display("FAIL b2b_ready_mid: got %b want 0", cmp_ready_o); else passed++;
      end
      @(negedge clk_i);
      cmp_valid_i = 1'b0;
    end
    for (int w = 0; w < 4; w++) send_beat({64{seq_b[w]}});
    total++; if (busy_o !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy_o); else passed++;
    repeat (3) @(negedge clk_i);
    total++; if (words_checked_o !== 32'd8) $display("FAIL b2b_words: got %0d want 8", words_checked_o); else passed++;
    total++; if (err_cnt_o !== 32'd0) $display("FAIL b2b_err_cnt: got %0d want 0", err_cnt_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL b2b_idle: got %b want 0", busy_o); else passed++;
  endtask

  task automatic test_wrap();
    logic [AMM_DATA_W-1:0] d;
    pulse_start();
    send_desc(mk_desc(1'b1, 8'd1, 26'h3FFFFFF, 6'd0, 6'd63, FIX_DATA, 8'h11));
    send_beat({64{8'h11}});
    d = {64{8'h11}};
    d[5*8 +: 8] = 8'h22;
    send_beat(d);
    repeat (3) @(negedge clk_i);
    total++; if (err_addr_o[ADDR_W-1:ADDR_B_W] !== 26'h0) $display("FAIL wrap_word: got %h want 0", err_addr_o[ADDR_W-1:ADDR_B_W]); else passed++;
    total++; if (err_addr_o !== 32'h5) $display("FAIL wrap_addr: got %h want 5", err_addr_o); else passed++;
  endtask

  task automatic test_zero_mask_and_clear();
    pulse_start();
    send_desc(mk_desc(1'b0, 8'd0, 26'h7, 6'd10, 6'd5, FIX_DATA, 8'h99));
    send_beat({64{8'h00}});
    repeat (3) @(negedge clk_i);
    total++; if (words_checked_o !== 32'd1) $display("FAIL zmask_words: got %0d want 1", words_checked_o); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL zmask_err: got %b want 0", err_o); else passed++;
    // Clear coincident with a bad beat: beat dropped, FSM back to IDLE.
    send_desc(mk_desc(1'b0, 8'd0, 26'h0, 6'd0, 6'd63, FIX_DATA, 8'h77));
    test_start_i = 1'b1;
    send_beat({64{8'h00}});
    test_start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    total++; if (words_checked_o !== 32'd0) $display("FAIL clr_beat_words: got %0d want 0", words_checked_o); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL clr_beat_err: got %b want 0", err_o); else passed++;
    total++; if (cmp_ready_o !== 1'b1) $display("FAIL clr_beat_idle: got %b want 1", cmp_ready_o); else passed++;
    // Clear coincident with an accept: the descriptor is still taken.
    test_start_i = 1'b1;
    send_desc(mk_desc(1'b0, 8'd0, 26'h0, 6'd0, 6'd63, FIX_DATA, 8'h77));
    test_start_i = 1'b0;
    total++; if (cmp_ready_o !== 1'b0) $display("FAIL clr_acc_state: got %b want 0", cmp_ready_o); else passed++;
    send_beat({64{8'h77}});
    repeat (3) @(negedge clk_i);
    total++; if (words_checked_o !== 32'd1) $display("FAIL clr_acc_words: got %0d want 1", words_checked_o); else passed++;
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_orphan();
    test_single_word();
    test_error_latch();
    test_burst();
    test_back_to_back();
    test_wrap();
    test_zero_mask_and_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/read_data_checker.md
Name: read_data_checker

Overview:
- Consumer of the read-side compare descriptors (cmp_struct_t) and the Avalon-MM read data returned from memory.
- For every returned word it builds the byte mask for that word, compares each enabled byte against the expected pattern, and latches the first mismatch.
- The latched address, actual byte and expected byte feed the CSR_TEST_RESULT, CSR_ERR_ADDR and CSR_ERR_DATA registers.
- Sits between the read-request generator's descriptor FIFO and the CSR block.

Parameters:
- CNT_W, 32, width of the checked-word and error counters.
- All other widths (AMM_DATA_W, DATA_B_W, ADDR_B_W, CMP_ADDR_W, ADDR_W, ADDR_TYPE) come from rtl_settings_pkg.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- test_start_i  in  1  one-cycle pulse; synchronously clears all sticky state and counters.
- cmp_struct_i  in  $bits(cmp_struct_t)  compare descriptor.
- cmp_valid_i  in  1  descriptor valid.
- cmp_ready_o  out  1  descriptor accepted when valid and ready are both high.
- readdatavalid_i  in  1  Avalon-MM readdatavalid.
- readdata_i  in  AMM_DATA_W  Avalon-MM readdata.
- busy_o  out  1  descriptor loaded or pipeline non-empty.
- err_o  out  1  sticky: first mismatch found.
- err_addr_o  out  ADDR_W  address of the first erroneous byte (BYTE mode) or word (WORD mode).
- err_data_o  out  8  actual byte read.
- err_exp_o  out  8  expected byte.
- words_checked_o  out  CNT_W  number of read words processed.
- err_cnt_o  out  CNT_W  number of words containing at least one mismatch; saturates.
- orphan_o  out  1  sticky: readdatavalid_i seen with no descriptor loaded.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pipeline empty. cmp_ready_o is 1 one cycle after rst_i deasserts.
- FSM IDLE:
  - cmp_ready_o=1.
  - On accept: register the descriptor, word_idx=0, exp=data_ptrn, then go to CHECK.
- FSM CHECK:
  - Word count: N = words_count+1 when trans_type=1; N=1 when trans_type=0.
  - Each readdatavalid_i advances word_idx.
  - On the beat where word_idx==N-1: cmp_ready_o=1 combinationally. A descriptor presented in that cycle is accepted and the FSM stays in CHECK with zero bubble; otherwise it returns to IDLE.
  - cmp_ready_o=0 in every other CHECK cycle.
- Byte mask, built with byteenable_ptrn:
  - first word: start_enable=1;
  - last word: end_enable=1;
  - single word (N=1): both;
  - middle words: all ones.
- Expected byte:
  - FIX_DATA: data_ptrn for every word.
  - RND_DATA: exp starts at data_ptrn and steps the package function lfsr8_next once per word (Galois, taps x^8+x^6+x^5+x^4+1). All bytes of one word share the same exp.
- Pipeline, 3 stages:
  - S0 registers readdata, mask, exp, word_addr = start_addr+word_idx (CMP_ADDR_W bits, wraps modulo 2^CMP_ADDR_W).
  - S1 computes check_vector.
  - S2 applies err_byte_find and updates the counters and latches.
  - err_o rises exactly 3 cycles after the readdatavalid_i of the offending beat.
  - words_checked_o increments 3 cycles after each beat.
- Error address:
  - BYTE mode: {word_addr, err_byte[ADDR_B_W-1:0]}.
  - WORD mode: word_addr.
- Latching: only the first error after test_start_i is latched; later mismatches increment err_cnt_o only.
- A zero mask (possible with start_off>end_off on a single word) counts as checked and never as an error.
- orphan_o: readdatavalid_i in IDLE sets orphan_o; the data is discarded and not counted.
- test_start_i coincident with readdatavalid_i: the clear wins; the in-flight beats are dropped and the FSM returns to IDLE.
- test_start_i coincident with a descriptor accept: the clear wins and the accept still occurs.
- busy_o = (state==CHECK) | any pipeline stage valid.

Decomposition:
- Add to rtl_settings_pkg:
  - lfsr8_next function;
  - cmp_state_t enum {IDLE, CHECK};
  - check_stage_t struct {valid, word_addr, mask, exp, data}.
- Reuse byteenable_ptrn, check_vector and err_byte_find unchanged.
- One sub-module: read_data_checker_pipe, holding the S0–S2 datapath. The top level holds the FSM, word_idx and the LFSR.

Test Plan:
- Single word: start_off=4, end_off=9, FIX 0xA5, all bytes 0xA5 except byte 3 = 0x00 -> err_o=0, words_checked_o=1.
- Same descriptor, byte 7 = 0x5A, start_addr=0x10 -> err_o rises 3 cycles after the beat; err_addr_o=(0x10<<6)|7; err_data_o=0x5A; err_exp_o=0xA5.
- Burst: trans_type=1, words_count=3, RND seed 0x01, correct LFSR data -> 4 words checked, err_o=0. Corrupt word 2 -> err_cnt_o=1 and the error address lies in word start_addr+2.
- Back-to-back: second descriptor valid during the last beat of the first -> accepted in the same cycle, no idle cycle, continuous readdatavalid_i for 8 words -> words_checked_o=8.
- readdatavalid_i pulse after reset with no descriptor -> orphan_o=1, words_checked_o=0. A following test_start_i clears orphan_o.
- start_addr=all-ones, words_count=1, error in word 1 -> word_addr wraps to 0, so err_addr_o[ADDR_W-1:ADDR_B_W]=0.
